btn_event_arbiter: RTL
======================

# btn_event_arbiter

Collects single-cycle button trigger pulses from a bank of synchronised edge detectors and latches each as a pending event. Events are serialised to one consumer (menu/game FSM) over a valid/ready interface with round-robin fairness and a programmable hold-off gap between delivered events. Lost presses are reported on a sticky overflow flag. Sits between the button front-end (sync + one-shot) and the application control logic.

## Interface

- N, default 4: number of trigger inputs (2..16).
- IDXW, default 2: event index width; 2**IDXW >= N required.
- HOLDOFF, default 16: idle cycles enforced after each accepted event (0 allowed; 0..65535).

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- trig  in  N  one-cycle event pulses, synchronous to clk, any number per cycle.
- ev_valid  out  1  event presented.
- ev_ready  in  1  consumer accepts event when high with ev_valid.
- ev_idx  out  IDXW  index of presented event; valid only while ev_valid=1, 0 otherwise.
- pending  out  N  registered per-input pending bits.
- drop  out  1  sticky: a trigger arrived while its pending bit was already set.
- drop_clr  in  1  clears drop.

## Operation

- Reset values: ev_valid=0, ev_idx=0, pending=0, drop=0, rr pointer=0, state IDLE, hold-off counter=0. Reset mid-operation discards all pending and in-flight events; no event is delivered after reset release until a new trig.
- Pending bits, per i, each clock:
  - trig[i]=1 -> pending[i] set.
  - Accept of event i (ev_valid & ev_ready & ev_idx==i) -> pending[i] cleared, unless trig[i]=1 same cycle (stays set; counts as new event, not a drop).
  - trig[i]=1 while pending[i]=1 and event i not accepted this cycle -> drop set; event merged (not counted twice).
- drop_clr=1 clears drop; simultaneous new drop condition wins (drop stays 1).
- FSM states:
  - IDLE: if pending != 0, select first set bit searching from pointer p upward, wrapping N-1 -> 0; register ev_idx, ev_valid<=1, go PRESENT. Else stay. Selection uses registered pending only, never same-cycle trig.
  - PRESENT: ev_valid=1, ev_idx stable until accept. On accept: ev_valid<=0, ev_idx<=0, p<=(idx+1) mod N; go HOLDOFF with counter=HOLDOFF-1 if HOLDOFF>0, else IDLE.
  - HOLDOFF: counter decrements each cycle; at counter==0 go IDLE. Exactly HOLDOFF cycles spent here.
- ev_valid never drops without acceptance; presented idx never changes mid-handshake.
- Pointer updates only on accept.

## Timing

- trig[i] in cycle t -> pending[i]=1 in t+1 -> ev_valid=1 in t+2 (arbiter in IDLE, no hold-off).
- Accept in cycle a -> ev_valid=0 in a+1; next ev_valid earliest a+HOLDOFF+2 (HOLDOFF=0: a+2).
- ev_ready high continuously: throughput one event per HOLDOFF+2 cycles.
- pending clear visible cycle after accept; drop set visible cycle after offending trig.
- All outputs registered; no combinational path from trig or ev_ready to any output.

## Test plan

- Latency: N=4, HOLDOFF=0, ev_ready=1, trig=4'b0010 at cycle 10 -> pending[1]=1 at 11, ev_valid=1 with ev_idx=1 at 12, ev_valid=0 and pending=0 at 13.
- Round-robin: after reset, trig=4'b1111 in one cycle, ev_ready=1, HOLDOFF=0 -> ev_idx sequence 0,1,2,3, spaced 2 cycles; then accept idx 2 alone and trig 4'b0101 -> next order 0 then 2 (pointer at 3 wraps to 0).
- Backpressure + hold-off: HOLDOFF=16, trig 0 and 1, ev_ready low 20 cycles -> ev_valid=1, ev_idx=0 held 20 cycles; raise ev_ready at a -> idx 1 presented exactly at a+18.
- Drop: trig[3] twice while ev_ready=0 -> drop=1 one cycle after second pulse, only one idx-3 event delivered; drop_clr=1 alone -> drop=0; drop_clr with new duplicate trig -> drop stays 1.
- Same-cycle retrigger: trig[2]=1 in the cycle idx 2 is accepted -> pending[2] stays 1, drop stays 0, second idx-2 event delivered after hold-off.
- Reset mid-PRESENT: assert rst while ev_valid=1, pending=4'b1010 -> all outputs 0 immediately; after release no ev_valid until new trig.

Source files
------------

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter
//   Latches one-cycle button trigger pulses as pending events and hands them,
//   one at a time, to a single consumer over a valid/ready handshake. Pending
//   events are chosen round-robin, starting from the slot after the last
//   accepted one. A programmable idle gap follows every accepted event. A
//   press that lands on an input whose event is still pending is merged into
//   that event and recorded on a sticky drop flag.
//
// Parameters
//   N        number of trigger inputs (2..16)
//   IDXW     event index width, 2**IDXW >= N
//   HOLDOFF  idle cycles after each accepted event (0..65535)
//
// Ports
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   trig      in   [N]    one-cycle event pulses, any number per cycle
//   ev_valid  out         event presented to the consumer
//   ev_ready  in          consumer accepts when high together with ev_valid
//   ev_idx    out  [IDXW] index of the presented event, 0 when idle
//   pending   out  [N]    registered per-input pending bits
//   drop      out         sticky: a press was merged into a pending event
//   drop_clr  in          clears drop
module btn_event_arbiter #(
  parameter int N       = 4,
  parameter int IDXW    = 2,
  parameter int HOLDOFF = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    trig,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [IDXW-1:0] ev_idx,
  output logic [N-1:0]    pending,
  output logic            drop,
  input  logic            drop_clr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_HOLD
  } state_t;

  // Counter load value: the counter runs HOLDOFF-1 down to 0, one state
  // visit per value, so the arbiter spends exactly HOLDOFF cycles in S_HOLD.
  localparam logic [15:0] HOLD_LOAD = (HOLDOFF > 0) ? 16'(HOLDOFF - 1) : 16'd0;

  state_t          r_state;
  logic [IDXW-1:0] r_ptr;
  logic [15:0]     r_cnt;
  logic [N-1:0]    r_pending;
  logic            r_drop;
  logic            r_ev_valid;
  logic [IDXW-1:0] r_ev_idx;

  logic            w_accept;
  logic [N-1:0]    w_acc_vec;
  logic [N-1:0]    w_pending_nxt;
  logic            w_dup;
  logic [IDXW-1:0] w_sel;
  logic [IDXW-1:0] w_ptr_nxt;

  // Round-robin pick: rotate the pending vector so the pointer slot lands at
  // bit 0, take the lowest set bit, then rotate the offset back.
  function automatic logic [IDXW-1:0] rr_pick(input logic [N-1:0]    pend,
                                               input logic [IDXW-1:0] ptr);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             off;
    dbl = {pend, pend} >> ptr;
    rot = dbl[N-1:0];
    off = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    return IDXW'((int'(ptr) + off) % N);
  endfunction

  assign w_accept  = r_ev_valid & ev_ready;
  assign w_sel     = rr_pick(r_pending, r_ptr);
  assign w_ptr_nxt = IDXW'((int'(r_ev_idx) + 1) % N);

  // A trigger in the same cycle as the accept of its own slot re-arms the
  // slot as a fresh event; it is not a drop.
  always_comb begin
    w_acc_vec     = '0;
    w_pending_nxt = '0;
    w_dup         = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_acc_vec[i]     = w_accept && (r_ev_idx == IDXW'(i));
      w_pending_nxt[i] = trig[i] | (r_pending[i] & ~w_acc_vec[i]);
      if (trig[i] && r_pending[i] && !w_acc_vec[i]) w_dup = 1'b1;
    end
  end

  // Pending/drop capture and the delivery FSM share one register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_pending  <= '0;
      r_drop     <= 1'b0;
      r_ev_valid <= 1'b0;
      r_ev_idx   <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      // A new merge in the same cycle as the clear keeps the flag set.
      r_drop    <= w_dup | (r_drop & ~drop_clr);
      case (r_state)
        S_IDLE: begin
          // Selection looks at registered pending only, never at trig.
          if (|r_pending) begin
            r_ev_idx   <= w_sel;
            r_ev_valid <= 1'b1;
            r_state    <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (ev_ready) begin
            r_ev_valid <= 1'b0;
            r_ev_idx   <= '0;
            r_ptr      <= w_ptr_nxt;
            if (HOLDOFF > 0) begin
              r_cnt   <= HOLD_LOAD;
              r_state <= S_HOLD;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (r_cnt == 16'd0) r_state <= S_IDLE;
          else                r_cnt   <= r_cnt - 16'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ev_valid = r_ev_valid;
  assign ev_idx   = r_ev_idx;
  assign pending  = r_pending;
  assign drop     = r_drop;

endmodule
